exmem_lsu: RTL and testbench

EXMEM_LSU -- requirements
Module: exmem_lsu

---
 rtl/exmem_lsu.sv | 166 ++++++++++++++++
 tb/tb_exmem_lsu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_lsu.sv
// Load/store unit for the EX/MEM stage: turns one aligned load or store into a
// single bus request/response transaction and writes load results back to rd.
module exmem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex2exmem_mem_en_i,
  input  logic        ex2exmem_wb_en_i,
  input  logic [31:0] ex2exmem_mem_addr_i,
  input  logic [31:0] ex2exmem_store_data_i,
  input  logic [6:0]  ex2exmem_opcode_i,
  input  logic [2:0]  ex2exmem_funct3_i,
  input  logic [4:0]  ex2exmem_rd_i,
  output logic        exmem2bus_req_o,
  output logic        exmem2bus_we_o,
  output logic [31:0] exmem2bus_addr_o,
  output logic [3:0]  exmem2bus_be_o,
  output logic [31:0] exmem2bus_wdata_o,
  input  logic        bus2exmem_gnt_i,
  input  logic        bus2exmem_rvalid_i,
  input  logic [31:0] bus2exmem_rdata_i,
  output logic        exmem2regs_wb_en_o,
  output logic [4:0]  exmem2regs_rd_addr_o,
  output logic [31:0] exmem2regs_rd_data_o,
  output logic        exmem2cu_stall_o,
  output logic        exmem2cu_misalign_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        is_load_q;
  logic        wb_en_q;
  logic [4:0]  rd_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;

  logic        is_load, is_store, legal, misaligned, candidate, accept;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode of the incoming op; only meaningful while IDLE.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_load  = (ex2exmem_opcode_i == OP_LOAD);
    is_store = (ex2exmem_opcode_i == OP_STORE);
    legal    = 1'b0;
    case (ex2exmem_funct3_i)
      3'b000, 3'b001, 3'b010: legal = is_load || is_store;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
    misaligned = ((ex2exmem_funct3_i[1:0] == 2'b01) && ex2exmem_mem_addr_i[0]) ||
                 ((ex2exmem_funct3_i[1:0] == 2'b10) && (ex2exmem_mem_addr_i[1:0] != 2'b00));
    candidate  = rst_n && (state == IDLE) && ex2exmem_mem_en_i && legal;
    accept     = candidate && !misaligned;
  end

  assign exmem2cu_misalign_o = candidate && misaligned;
  assign exmem2cu_stall_o    = accept || (state == REQ) || (state == WAIT);

  // Store lane steering; loads always request the full word.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = ex2exmem_store_data_i;
    if (is_store) begin
      case (ex2exmem_funct3_i[1:0])
        2'b00: begin
          be_n    = 4'b0001 << ex2exmem_mem_addr_i[1:0];
          wdata_n = {4{ex2exmem_store_data_i[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << {ex2exmem_mem_addr_i[1], 1'b0};
          wdata_n = {2{ex2exmem_store_data_i[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = ex2exmem_store_data_i;
        end
      endcase
    end
  end

  // Load lane extraction and extension from the captured offset/funct3.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus2exmem_rdata_i[7:0];
      2'd1:    ld_byte = bus2exmem_rdata_i[15:8];
      2'd2:    ld_byte = bus2exmem_rdata_i[23:16];
      default: ld_byte = bus2exmem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? bus2exmem_rdata_i[31:16] : bus2exmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus2exmem_rdata_i;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      is_load_q            <= 1'b0;
      wb_en_q              <= 1'b0;
      rd_q                 <= 5'd0;
      off_q                <= 2'd0;
      funct3_q             <= 3'd0;
      exmem2bus_req_o      <= 1'b0;
      exmem2bus_we_o       <= 1'b0;
      exmem2bus_addr_o     <= 32'h0;
      exmem2bus_be_o       <= 4'b0000;
      exmem2bus_wdata_o    <= 32'h0;
      exmem2regs_wb_en_o   <= 1'b0;
      exmem2regs_rd_addr_o <= 5'd0;
      exmem2regs_rd_data_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_load_q         <= is_load;
            wb_en_q           <= ex2exmem_wb_en_i;
            rd_q              <= ex2exmem_rd_i;
            off_q             <= ex2exmem_mem_addr_i[1:0];
            funct3_q          <= ex2exmem_funct3_i;
            exmem2bus_req_o   <= 1'b1;
            exmem2bus_we_o    <= is_store;
            exmem2bus_addr_o  <= {ex2exmem_mem_addr_i[31:2], 2'b00};
            exmem2bus_be_o    <= be_n;
            exmem2bus_wdata_o <= wdata_n;
            state             <= REQ;
          end
        end
        REQ: begin
          if (bus2exmem_gnt_i) begin
            exmem2bus_req_o <= 1'b0;
            exmem2bus_we_o  <= 1'b0;
            state           <= is_load_q ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (bus2exmem_rvalid_i) begin
            if (wb_en_q && (rd_q != 5'd0)) begin
              exmem2regs_wb_en_o   <= 1'b1;
              exmem2regs_rd_addr_o <= rd_q;
              exmem2regs_rd_data_o <= ld_data;
            end
            state <= DONE;
          end
        end
        default: begin
          exmem2regs_wb_en_o <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exmem_lsu.sv
// Randomized bench for exmem_lsu: per-cycle checks against a transaction-level
// model of size/offset arithmetic, plus directed cases and reset aborts.
module tb_exmem_lsu;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk, rst_n;
  logic        mem_en, wb_en;
  logic [31:0] mem_addr, store_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        req, we;
  logic [31:0] bus_addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        wb_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        stall, misalign;

  int total = 0;
  int bad   = 0;
  logic [4:0]  last_rd   = 5'd0;
  logic [31:0] last_data = 32'h0;

  exmem_lsu dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex2exmem_mem_en_i    (mem_en),
    .ex2exmem_wb_en_i     (wb_en),
    .ex2exmem_mem_addr_i  (mem_addr),
    .ex2exmem_store_data_i(store_data),
    .ex2exmem_opcode_i    (opcode),
    .ex2exmem_funct3_i    (funct3),
    .ex2exmem_rd_i        (rd),
    .exmem2bus_req_o      (req),
    .exmem2bus_we_o       (we),
    .exmem2bus_addr_o     (bus_addr),
    .exmem2bus_be_o       (be),
    .exmem2bus_wdata_o    (wdata),
    .bus2exmem_gnt_i      (gnt),
    .bus2exmem_rvalid_i   (rvalid),
    .bus2exmem_rdata_i    (rdata),
    .exmem2regs_wb_en_o   (wb_en_o),
    .exmem2regs_rd_addr_o (rd_addr_o),
    .exmem2regs_rd_data_o (rd_data_o),
    .exmem2cu_stall_o     (stall),
    .exmem2cu_misalign_o  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic ld, input logic [2:0] f3, input logic [31:0] a);
    int lanes;
    if (ld) return 4'hF;
    lanes = ((1 << op_size(f3)) - 1) << int'(a & 32'd3);
    return 4'(lanes);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int size;
    size = op_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    int size;
    logic [31:0] mask, val;
    size = op_size(f3);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    val  = (r >> (8 * int'(a & 32'd3))) & mask;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
    return val;
  endfunction

  task automatic idle_inputs();
    mem_en = 1'b0; wb_en = 1'b0; mem_addr = 32'h0; store_data = 32'h0;
    opcode = 7'h0; funct3 = 3'h0; rd = 5'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
  endtask

  // Plausible-looking ops on the inputs while busy; all must be ignored.
  task automatic junk_inputs();
    mem_en     = 1'($urandom);
    wb_en      = 1'($urandom);
    mem_addr   = $urandom;
    store_data = $urandom;
    opcode     = ($urandom % 2 == 0) ? OP_LOAD : OP_STORE;
    funct3     = 3'($urandom);
    rd         = 5'($urandom);
  endtask

  // Called just after a rising edge with the DUT idle; returns likewise.
  task automatic run_op(input logic men, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdi,
                        input logic wbe, input int gw, input int rw, input logic [31:0] rdat);
    logic is_ld, is_st, legal, mis, acc, exp_wb;
    int size;
    is_ld  = (opc == OP_LOAD);
    is_st  = (opc == OP_STORE);
    legal  = (is_ld && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
             (is_st && f3 inside {3'd0, 3'd1, 3'd2});
    size   = op_size(f3);
    mis    = men && legal && (int'(a & 32'd3) % size != 0);
    acc    = men && legal && !mis;
    exp_wb = is_ld && wbe && (rdi != 5'd0);

    mem_en = men; opcode = opc; funct3 = f3; mem_addr = a; store_data = d;
    rd = rdi; wb_en = wbe; gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
    @(negedge clk);
    check("idle_stall", stall, acc);
    check("idle_misalign", misalign, mis);
    check("idle_req", req, 0);
    check("idle_wb", wb_en_o, 0);
    check("idle_rd_hold", rd_addr_o, last_rd);
    check("idle_data_hold", rd_data_o, last_data);
    @(posedge clk); #1;

    if (!acc) begin
      idle_inputs();
      @(negedge clk);
      check("rej_req", req, 0);
      check("rej_stall", stall, 0);
      check("rej_misalign", misalign, 0);
      check("rej_wb", wb_en_o, 0);
      @(posedge clk); #1;
      return;
    end

    for (int k = 0; k <= gw; k++) begin
      junk_inputs();
      gnt = (k == gw); rvalid = 1'($urandom); rdata = $urandom;
      @(negedge clk);
      check("req_req", req, 1);
      check("req_addr", bus_addr, a & ~32'd3);
      check("req_be", be, exp_be(is_ld, f3, a));
      check("req_we", we, is_st);
      if (is_st) check("req_wdata", wdata, exp_wdata(f3, d));
      check("req_stall", stall, 1);
      check("req_misalign", misalign, 0);
      check("req_wb", wb_en_o, 0);
      @(posedge clk); #1;
    end

    if (is_ld) begin
      for (int k = 0; k <= rw; k++) begin
        junk_inputs();
        gnt = 1'($urandom); rvalid = (k == rw);
        rdata = (k == rw) ? rdat : $urandom;
        @(negedge clk);
        check("wait_req", req, 0);
        check("wait_stall", stall, 1);
        check("wait_misalign", misalign, 0);
        check("wait_wb", wb_en_o, 0);
        @(posedge clk); #1;
      end
    end

    junk_inputs();
    gnt = 1'($urandom); rvalid = 1'($urandom); rdata = $urandom;
    if (exp_wb) begin
      last_rd   = rdi;
      last_data = exp_load(f3, a, rdat);
    end
    @(negedge clk);
    check("done_req", req, 0);
    check("done_stall", stall, 0);
    check("done_misalign", misalign, 0);
    check("done_wb", wb_en_o, exp_wb);
    check("done_rd", rd_addr_o, last_rd);
    check("done_data", rd_data_o, last_data);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, req, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_be"}, be, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_wb"}, wb_en_o, 0);
    check({tag, "_rd"}, rd_addr_o, 0);
    check({tag, "_data"}, rd_data_o, 0);
    check({tag, "_misalign"}, misalign, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Directed cases; the first op is accepted on the first edge after release.
    run_op(1, OP_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0, 0, 0, 0);
    run_op(1, OP_STORE, 3'b000, 32'h203, 32'h000000A5, 5'd1, 0, 0, 0, 0);
    run_op(1, OP_LOAD,  3'b000, 32'h101, 32'h0, 5'd5, 1, 0, 3, 32'h0000_80FF);
    check("lb_value", rd_data_o, 32'hFFFFFF80);
    run_op(1, OP_LOAD,  3'b100, 32'h101, 32'h0, 5'd5, 1, 0, 3, 32'h0000_80FF);
    check("lbu_value", rd_data_o, 32'h00000080);
    run_op(1, OP_LOAD,  3'b010, 32'h102, 32'h0, 5'd6, 1, 0, 0, 32'h12345678);
    run_op(1, OP_LOAD,  3'b001, 32'h102, 32'h0, 5'd6, 1, 0, 0, 32'h8001_1234);
    check("lh_value", rd_data_o, 32'hFFFF8001);
    run_op(1, OP_LOAD,  3'b010, 32'h104, 32'h0, 5'd0, 1, 1, 1, 32'hCAFEF00D);
    check("lw_rd0_keep", rd_addr_o, 5'd6);
    run_op(1, OP_LOAD,  3'b011, 32'h108, 32'h0, 5'd3, 1, 0, 0, 32'h1);
    run_op(1, 7'h13,    3'b010, 32'h108, 32'h0, 5'd3, 1, 0, 0, 32'h1);
    run_op(1, OP_STORE, 3'b001, 32'h10E, 32'h0000BEEF, 5'd0, 0, 2, 0, 0);

    // Reset while waiting for read data, then a late rvalid in IDLE.
    mem_en = 1; opcode = OP_LOAD; funct3 = 3'b010; mem_addr = 32'h300; rd = 5'd7; wb_en = 1;
    @(posedge clk); #1;
    mem_en = 0; gnt = 1;
    @(posedge clk); #1;
    gnt = 0;
    @(negedge clk);
    check("abort_in_wait", stall, 1);
    rst_n = 1'b0;
    #1;
    last_rd = 5'd0; last_data = 32'h0;
    check_reset_outputs("rst1");
    @(posedge clk); #1;
    rvalid = 1; rdata = 32'hFFFF_FFFF;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("late_rv_wb", wb_en_o, 0);
    @(posedge clk); #1;
    rvalid = 0;
    @(negedge clk);
    check("late_rv_wb2", wb_en_o, 0);
    check("late_rv_req", req, 0);
    check("late_rv_data", rd_data_o, 0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [6:0]  opc;
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      opc = (sel < 5) ? OP_LOAD : (sel < 9) ? OP_STORE : 7'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op(($urandom_range(0, 7) != 0), opc, 3'($urandom), a, $urandom,
             ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
